half_adder: RTL and testbench
=============================

Name: half_adder

Overview:
- Registered 1-bit half adder, replicated across WIDTH independent lanes.
- Each lane produces sum = a XOR b and carry = a AND b, captured on the clock edge.
- It is a leaf arithmetic primitive, used as a building block for ripple and carry-save adder trees and for incrementer stages elsewhere in the datapath.

Parameters:
- WIDTH, 1, number of independent half-adder lanes. Lane i uses a[i] and b[i] and drives sum[i] and ca[i]. Legal range is 1..64.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous active-high reset.
- en  input  1  capture enable. When high, the current a/b result is registered on the next rising edge.
- a  input  WIDTH  addend A, one bit per lane.
- b  input  WIDTH  addend B, one bit per lane.
- sum  output  WIDTH  registered lane sums, a XOR b.
- ca  output  WIDTH  registered lane carries, a AND b.
- vld  output  1  high for exactly the cycle after each enabled capture, marking new sum/ca.

Behaviour:
- One clock, synchronous active-high reset. All state updates only on the rising edge of clk.
- Reset:
  - If rst = 1 at a rising edge, then sum = 0, ca = 0 and vld = 0 after that edge.
  - rst has priority over en.
  - Reset while en = 1 discards that cycle's inputs.
- Capture: if rst = 0 and en = 1 at a rising edge:
  - sum[i] <= a[i] ^ b[i] for every lane i.
  - ca[i] <= a[i] & b[i] for every lane i.
  - vld <= 1.
- Hold: if rst = 0 and en = 0 at a rising edge:
  - sum and ca keep their previous values.
  - vld <= 0.
- Latency: 1 cycle from input sampling to output. Throughput is one result per cycle while en is held high.
- Lanes are fully independent. There is no carry propagation between lanes; ca[i] is never added into lane i+1.
- Per-lane truth table (a, b -> sum, ca):
  - 0,0 -> 0,0
  - 0,1 -> 1,0
  - 1,0 -> 1,0
  - 1,1 -> 0,1
- Invariant: sum[i] and ca[i] are never both 1.
- Outputs are driven only from registers, with no combinational path from a, b or en to any output.
- Inputs a and b are sampled only at the clock edge; glitches between edges have no effect.
- X on a or b while en = 0 must not disturb the outputs.
- No handshake back-pressure exists. vld is informational only, and downstream logic that misses a vld pulse loses that result.
- Back-to-back enabled cycles produce back-to-back vld pulses, so vld stays continuously high while en stays high.
- Power-up: state before the first reset is undefined. The bench applies rst for at least one edge first.

Test Plan:
- Reset: WIDTH=1, rst=1 for 2 edges with en=1, a=1, b=1 -> sum=0, ca=0, vld=0 after each edge. Release rst -> outputs stay 0 until an enabled edge.
- Exhaustive truth table: WIDTH=1, en=1, apply (a,b) = (0,0), (0,1), (1,0), (1,1) on consecutive edges -> one cycle later (sum,ca) = (0,0), (1,0), (1,0), (0,1), with vld=1 on each.
- Hold: after capturing a=1, b=1 (ca=1), set en=0 and a=0, b=1 for 3 edges -> sum=0 and ca=1 unchanged, vld=0.
- Multi-lane: WIDTH=4, a=4'b1100, b=4'b1010, en=1 -> next edge gives sum=4'b0110, ca=4'b1000, vld=1. Confirm no inter-lane carry.
- Reset mid-stream: en=1 with changing inputs, assert rst for one edge -> sum=0, ca=0, vld=0. Next enabled edge with a=1, b=0 -> sum=1, ca=0, vld=1.
- Randomised: WIDTH=8, 1000 cycles with random en, a, b and occasional rst -> outputs match a 1-cycle-delayed reference model. Check sum & ca == 0 every cycle.

Source files
------------

// File: rtl/half_adder.sv
// half_adder: registered 1-bit half adder replicated over WIDTH independent lanes.
//
// Each lane captures sum = a ^ b and ca = a & b on a rising clk edge when en is
// high. Lanes are independent, so no carry ever moves from lane i into lane i+1.
// vld pulses for the cycle after each enabled capture.
//
// Ports:
//   clk  in   1      rising-edge clock
//   rst  in   1      synchronous active-high reset, wins over en
//   en   in   1      capture enable
//   a    in   WIDTH  addend A, one bit per lane
//   b    in   WIDTH  addend B, one bit per lane
//   sum  out  WIDTH  registered lane sums
//   ca   out  WIDTH  registered lane carries
//   vld  out  1      new sum/ca present this cycle

// One lane. The data registers do not load while en is low, so X on a or b in
// that state cannot reach the outputs.
module half_adder_lane (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic ca
);
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= 1'b0;
      ca  <= 1'b0;
    end else if (en) begin
      sum <= a ^ b;
      ca  <= a & b;
    end
  end
endmodule

module half_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] ca,
  output logic             vld
);
  logic vld_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_lane u_lane (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .a   (a[i]),
      .b   (b[i]),
      .sum (sum[i]),
      .ca  (ca[i])
    );
  end

  // vld follows en by one cycle, so it stays high while en is held high.
  always_ff @(posedge clk) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= en;
  end

  assign vld = vld_q;
endmodule

// File: tb/tb_half_adder.sv
module tb_half_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r1, e1, v1;
  logic [0:0] a1, b1, s1, c1;
  logic       r4, e4, v4;
  logic [3:0] a4, b4, s4, c4;
  logic       r8, e8, v8;
  logic [7:0] a8, b8, s8, c8;

  half_adder #(.WIDTH(1)) u1 (.clk(clk), .rst(r1), .en(e1), .a(a1), .b(b1), .sum(s1), .ca(c1), .vld(v1));
  half_adder #(.WIDTH(4)) u4 (.clk(clk), .rst(r4), .en(e4), .a(a4), .b(b4), .sum(s4), .ca(c4), .vld(v4));
  half_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(r8), .en(e8), .a(a8), .b(b8), .sum(s8), .ca(c8), .vld(v8));

  int checks = 0;
  int errors = 0;

  // reference state for the 8-lane instance
  logic [7:0] m_sum, m_ca;
  logic       m_vld;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic s, input logic c, input logic v);
    chk({tag, ".sum"}, 64'(s1), 64'(s));
    chk({tag, ".ca"},  64'(c1), 64'(c));
    chk({tag, ".vld"}, 64'(v1), 64'(v));
  endtask

  // Model one edge of the 8-lane unit: each lane's two input bits are added as
  // integers; the low bit of that sum is the lane sum, the high bit the carry.
  task automatic model8(input logic rst, input logic en, input logic [7:0] a, input logic [7:0] b);
    if (rst) begin
      m_sum = '0; m_ca = '0; m_vld = 1'b0;
    end else if (en) begin
      for (int i = 0; i < 8; i++) begin
        int t;
        t = int'(a[i]) + int'(b[i]);
        m_sum[i] = (t % 2) == 1;
        m_ca[i]  = (t / 2) == 1;
      end
      m_vld = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
  endtask

  initial begin
    logic [1:0] tt_in [4];
    logic [1:0] tt_out [4];
    tt_in[0] = 2'b00; tt_out[0] = 2'b00;
    tt_in[1] = 2'b01; tt_out[1] = 2'b10;
    tt_in[2] = 2'b10; tt_out[2] = 2'b10;
    tt_in[3] = 2'b11; tt_out[3] = 2'b01;

    // reset all three with enable and data active; those inputs must be discarded
    r1 = 1; e1 = 1; a1 = 1; b1 = 1;
    r4 = 1; e4 = 1; a4 = '1; b4 = '1;
    r8 = 1; e8 = 1; a8 = '1; b8 = '1;
    model8(1'b1, 1'b1, '1, '1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk1("rst1", 1'b0, 1'b0, 1'b0);
    end
    chk("rst4.sum", 64'(s4), 64'(0));
    chk("rst4.ca",  64'(c4), 64'(0));
    chk("rst4.vld", 64'(v4), 64'(0));
    chk("rst8.sum", 64'(s8), 64'(m_sum));

    // release with en low: outputs stay zero
    r1 = 0; e1 = 0; r4 = 0; e4 = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk1("idle1", 1'b0, 1'b0, 1'b0);
    end

    // truth table on consecutive enabled edges
    e1 = 1;
    for (int k = 0; k < 4; k++) begin
      a1 = tt_in[k][1]; b1 = tt_in[k][0];
      tick();
      chk1($sformatf("tt%0d", k), tt_out[k][1], tt_out[k][0], 1'b1);
    end

    // hold after capturing 1,1; a driven to X must not matter
    e1 = 0; a1 = 1'bx; b1 = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("hold1", 1'b0, 1'b1, 1'b0);
    end

    // reset in the middle of enabled traffic
    e1 = 1; a1 = 0; b1 = 1;
    tick();
    chk1("mid_pre", 1'b1, 1'b0, 1'b1);
    r1 = 1; a1 = 1; b1 = 1;
    tick();
    chk1("mid_rst", 1'b0, 1'b0, 1'b0);
    r1 = 0; a1 = 1; b1 = 0;
    tick();
    chk1("mid_post", 1'b1, 1'b0, 1'b1);

    // multi-lane: no carry crosses lanes
    e4 = 1; a4 = 4'b1100; b4 = 4'b1010;
    tick();
    chk("ml0.sum", 64'(s4), 64'(4'b0110));
    chk("ml0.ca",  64'(c4), 64'(4'b1000));
    chk("ml0.vld", 64'(v4), 64'(1));
    a4 = 4'b1111; b4 = 4'b0001;
    tick();
    chk("ml1.sum", 64'(s4), 64'(4'b1110));
    chk("ml1.ca",  64'(c4), 64'(4'b0001));
    chk("ml1.vld", 64'(v4), 64'(1));
    e4 = 0; a4 = 4'b0000; b4 = 4'b0000;
    tick();
    chk("ml2.sum", 64'(s4), 64'(4'b1110));
    chk("ml2.vld", 64'(v4), 64'(0));

    // randomised 8-lane run against the model
    for (int k = 0; k < 1000; k++) begin
      r8 = ($urandom_range(0, 31) == 0);
      e8 = $urandom_range(0, 1);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      tick();
      model8(r8, e8, a8, b8);
      chk("rnd.sum", 64'(s8), 64'(m_sum));
      chk("rnd.ca",  64'(c8), 64'(m_ca));
      chk("rnd.vld", 64'(v8), 64'(m_vld));
      chk("rnd.excl", 64'(s8 & c8), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
